// File: rtl/gty_ctrl_pkg.sv
// Shared state encodings, default timing constants and the registered output bundle.
package gty_ctrl_pkg;

   localparam int unsigned ST_W = 4;

   localparam logic [ST_W-1:0] ST_IDLE     = 4'd0;
   localparam logic [ST_W-1:0] ST_WAIT_PWR = 4'd1;
   localparam logic [ST_W-1:0] ST_RST_ALL  = 4'd2;
   localparam logic [ST_W-1:0] ST_WAIT_PMA = 4'd3;
   localparam logic [ST_W-1:0] ST_WAIT_TX  = 4'd4;
   localparam logic [ST_W-1:0] ST_WAIT_RX  = 4'd5;
   localparam logic [ST_W-1:0] ST_LINK_UP  = 4'd6;
   localparam logic [ST_W-1:0] ST_RX_RST   = 4'd7;
   localparam logic [ST_W-1:0] ST_FAULT    = 4'd8;

   localparam int unsigned DEF_RESET_HOLD_CYCLES    = 16;
   localparam int unsigned DEF_USRCLK_SETTLE_CYCLES = 64;
   localparam int unsigned DEF_TIMEOUT_CYCLES       = 1048576;
   localparam int unsigned DEF_MAX_RETRIES          = 3;
   localparam int unsigned DEF_CDR_FILTER_CYCLES    = 8;

   typedef struct packed {
      logic reset_all;
      logic rx_datapath;
      logic userclk_tx_active;
      logic userclk_rx_active;
      logic link_up;
      logic fault;
   } gty_ctrl_out_t;

   // States guarded by the bring-up timeout.
   function automatic logic is_wait_state(input logic [ST_W-1:0] st);
      return (st == ST_WAIT_PMA) || (st == ST_WAIT_TX) || (st == ST_WAIT_RX);
   endfunction

   // Output levels owned by each state; unknown encodings hold the GT in reset.
   function automatic gty_ctrl_out_t decode_outputs(input logic [ST_W-1:0] st);
      gty_ctrl_out_t o;
      o = '0;
      case (st)
         ST_WAIT_PMA: o = '0;
         ST_WAIT_TX, ST_WAIT_RX: begin
            o.userclk_tx_active = 1'b1;
            o.userclk_rx_active = 1'b1;
         end
         ST_LINK_UP: begin
            o.userclk_tx_active = 1'b1;
            o.userclk_rx_active = 1'b1;
            o.link_up           = 1'b1;
         end
         ST_RX_RST: begin
            o.userclk_tx_active = 1'b1;
            o.userclk_rx_active = 1'b1;
            o.rx_datapath       = 1'b1;
         end
         ST_FAULT: begin
            o.reset_all = 1'b1;
            o.fault     = 1'b1;
         end
         default: o.reset_all = 1'b1;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/gty_sync_2ff.sv
// Two-flop level synchronizer into the free-running reset clock domain.
module gty_sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Capture stage followed by the settled output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/gty_link_bringup_ctrl.sv
// Bring-up and recovery sequencer for one GTY channel on the free-running reset clock.
module gty_link_bringup_ctrl
   import gty_ctrl_pkg::*;
#(
   parameter int unsigned RESET_HOLD_CYCLES    = DEF_RESET_HOLD_CYCLES,
   parameter int unsigned USRCLK_SETTLE_CYCLES = DEF_USRCLK_SETTLE_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES       = DEF_TIMEOUT_CYCLES,
   parameter int unsigned MAX_RETRIES          = DEF_MAX_RETRIES,
   parameter int unsigned CDR_FILTER_CYCLES    = DEF_CDR_FILTER_CYCLES
) (
   input  logic            gtwiz_reset_clk_freerun_in,
   input  logic            rst_in,
   input  logic            link_restart_in,
   input  logic            rx_reset_req_in,
   input  logic            gtpowergood_in,
   input  logic            txpmaresetdone_in,
   input  logic            rxpmaresetdone_in,
   input  logic            gtwiz_reset_tx_done_in,
   input  logic            gtwiz_reset_rx_done_in,
   input  logic            gtwiz_reset_rx_cdr_stable_in,
   output logic            gtwiz_reset_all_out,
   output logic            gtwiz_reset_rx_datapath_out,
   output logic            gtwiz_userclk_tx_active_out,
   output logic            gtwiz_userclk_rx_active_out,
   output logic            link_up_out,
   output logic            fault_out,
   output logic [ST_W-1:0] state_out,
   output logic [3:0]      retry_count_out
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned SET_W = $clog2(USRCLK_SETTLE_CYCLES + 1);
   localparam int unsigned CDR_W = $clog2(CDR_FILTER_CYCLES + 1);

   localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [SET_W-1:0] SET_MAX   = SET_W'(USRCLK_SETTLE_CYCLES);
   localparam logic [SET_W-1:0] SET_LAST  = SET_W'(USRCLK_SETTLE_CYCLES - 1);
   localparam logic [CDR_W-1:0] CDR_MAX   = CDR_W'(CDR_FILTER_CYCLES);
   localparam logic [CDR_W-1:0] CDR_LAST  = CDR_W'(CDR_FILTER_CYCLES - 1);
   localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

   logic clk;
   assign clk = gtwiz_reset_clk_freerun_in;

   logic pg_s, txpma_s, rxpma_s, txdone_s, rxdone_s, cdr_s;

   gty_sync_2ff u_sync_pg     (.clk(clk), .rst(rst_in), .d(gtpowergood_in),               .q(pg_s));
   gty_sync_2ff u_sync_txpma  (.clk(clk), .rst(rst_in), .d(txpmaresetdone_in),            .q(txpma_s));
   gty_sync_2ff u_sync_rxpma  (.clk(clk), .rst(rst_in), .d(rxpmaresetdone_in),            .q(rxpma_s));
   gty_sync_2ff u_sync_txdone (.clk(clk), .rst(rst_in), .d(gtwiz_reset_tx_done_in),       .q(txdone_s));
   gty_sync_2ff u_sync_rxdone (.clk(clk), .rst(rst_in), .d(gtwiz_reset_rx_done_in),       .q(rxdone_s));
   gty_sync_2ff u_sync_cdr    (.clk(clk), .rst(rst_in), .d(gtwiz_reset_rx_cdr_stable_in), .q(cdr_s));

   logic restart_q, restart_prev_q, rxreq_q, rxreq_prev_q;
   logic restart_edge, rxreq_edge;

   // Register the GPIO request levels and keep the previous sample for edge detection.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         restart_q      <= 1'b0;
         restart_prev_q <= 1'b0;
         rxreq_q        <= 1'b0;
         rxreq_prev_q   <= 1'b0;
      end else begin
         restart_q      <= link_restart_in;
         restart_prev_q <= restart_q;
         rxreq_q        <= rx_reset_req_in;
         rxreq_prev_q   <= rxreq_q;
      end
   end

   assign restart_edge = restart_q & ~restart_prev_q;
   assign rxreq_edge   = rxreq_q & ~rxreq_prev_q;

   logic [ST_W-1:0]  state_q, state_d;
   logic [3:0]       retry_q, retry_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [CDR_W-1:0] cdr_q, cdr_d;
   logic             enter, timeout, pma_ok, cdr_loss;
   gty_ctrl_out_t    out_q, out_d;

   assign pma_ok   = txpma_s & rxpma_s;
   assign timeout  = is_wait_state(state_q) && (timer_q == TMR_LAST);
   assign cdr_loss = ~cdr_s && (cdr_q == CDR_LAST);

   // Next state and retry count, highest-priority event first.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      enter   = 1'b0;
      if (restart_edge) begin
         state_d = ST_RST_ALL;
         retry_d = '0;
         enter   = 1'b1;
      end else if (!pg_s && (state_q != ST_IDLE) && (state_q != ST_WAIT_PWR) &&
                   (state_q != ST_FAULT)) begin
         state_d = ST_WAIT_PWR;
         enter   = 1'b1;
      end else if (timeout) begin
         enter = 1'b1;
         if (retry_q == RETRY_MAX) begin
            state_d = ST_FAULT;
         end else begin
            state_d = ST_RST_ALL;
            retry_d = retry_q + 4'd1;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_PWR;
               enter   = 1'b1;
            end
            ST_WAIT_PWR: if (pg_s) begin
               state_d = ST_RST_ALL;
               enter   = 1'b1;
            end
            ST_RST_ALL: if (timer_q == HOLD_LAST) begin
               state_d = ST_WAIT_PMA;
               enter   = 1'b1;
            end
            ST_WAIT_PMA: if (pma_ok && (settle_q == SET_LAST)) begin
               state_d = ST_WAIT_TX;
               enter   = 1'b1;
            end
            ST_WAIT_TX: if (txdone_s) begin
               state_d = ST_WAIT_RX;
               enter   = 1'b1;
            end
            ST_WAIT_RX: if (rxdone_s) begin
               state_d = ST_LINK_UP;
               enter   = 1'b1;
            end
            ST_LINK_UP: begin
               if (!txdone_s) begin
                  state_d = ST_RST_ALL;
                  enter   = 1'b1;
               end else if (rxreq_edge || cdr_loss) begin
                  state_d = ST_RX_RST;
                  enter   = 1'b1;
               end
            end
            ST_RX_RST: if (timer_q == HOLD_LAST) begin
               state_d = ST_WAIT_RX;
               enter   = 1'b1;
            end
            ST_FAULT: state_d = ST_FAULT;
            default: begin
               state_d = ST_IDLE;
               enter   = 1'b1;
            end
         endcase
      end
   end

   // State timer, PMA settle counter and CDR-loss filter; all saturate and clear on entry.
   always_comb begin
      timer_d  = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
      settle_d = '0;
      cdr_d    = '0;
      if (enter) begin
         timer_d = '0;
      end else begin
         if ((state_q == ST_WAIT_PMA) && pma_ok) begin
            settle_d = (settle_q == SET_MAX) ? settle_q : settle_q + SET_W'(1);
         end
         if ((state_q == ST_LINK_UP) && !cdr_s) begin
            cdr_d = (cdr_q == CDR_MAX) ? cdr_q : cdr_q + CDR_W'(1);
         end
      end
   end

   assign out_d = decode_outputs(state_d);

   // Sequencer state, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q  <= ST_IDLE;
         retry_q  <= '0;
         timer_q  <= '0;
         settle_q <= '0;
         cdr_q    <= '0;
         out_q    <= decode_outputs(ST_IDLE);
      end else begin
         state_q  <= state_d;
         retry_q  <= retry_d;
         timer_q  <= timer_d;
         settle_q <= settle_d;
         cdr_q    <= cdr_d;
         out_q    <= out_d;
      end
   end

   assign gtwiz_reset_all_out         = out_q.reset_all;
   assign gtwiz_reset_rx_datapath_out = out_q.rx_datapath;
   assign gtwiz_userclk_tx_active_out = out_q.userclk_tx_active;
   assign gtwiz_userclk_rx_active_out = out_q.userclk_rx_active;
   assign link_up_out                 = out_q.link_up;
   assign fault_out                   = out_q.fault;
   assign state_out                   = state_q;
   assign retry_count_out             = retry_q;

endmodule

// File: tb/tb_gty_link_bringup_ctrl.sv
// Directed scenario bench for the GTY bring-up sequencer (HOLD=16, SETTLE=64, TIMEOUT=200).
module tb_gty_link_bringup_ctrl;

   logic       clk = 1'b0;
   logic       rst_in, link_restart_in, rx_reset_req_in;
   logic       gtpowergood_in, txpmaresetdone_in, rxpmaresetdone_in;
   logic       tx_done_in, rx_done_in, cdr_stable_in;
   logic       reset_all, rx_dp, tx_act, rx_act, link_up, fault;
   logic [3:0] state_out, retry_out;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gty_link_bringup_ctrl #(
      .RESET_HOLD_CYCLES   (16),
      .USRCLK_SETTLE_CYCLES(64),
      .TIMEOUT_CYCLES      (200),
      .MAX_RETRIES         (3),
      .CDR_FILTER_CYCLES   (8)
   ) dut (
      .gtwiz_reset_clk_freerun_in  (clk),
      .rst_in                      (rst_in),
      .link_restart_in             (link_restart_in),
      .rx_reset_req_in             (rx_reset_req_in),
      .gtpowergood_in              (gtpowergood_in),
      .txpmaresetdone_in           (txpmaresetdone_in),
      .rxpmaresetdone_in           (rxpmaresetdone_in),
      .gtwiz_reset_tx_done_in      (tx_done_in),
      .gtwiz_reset_rx_done_in      (rx_done_in),
      .gtwiz_reset_rx_cdr_stable_in(cdr_stable_in),
      .gtwiz_reset_all_out         (reset_all),
      .gtwiz_reset_rx_datapath_out (rx_dp),
      .gtwiz_userclk_tx_active_out (tx_act),
      .gtwiz_userclk_rx_active_out (rx_act),
      .link_up_out                 (link_up),
      .fault_out                   (fault),
      .state_out                   (state_out),
      .retry_count_out             (retry_out)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick(1);
         if (state_out == s) begin n = i; break; end
      end
   endtask

   task automatic wait_retry(input logic [3:0] r, input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick(1);
         if (retry_out == r) begin n = i; break; end
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1; link_restart_in = 1'b0; rx_reset_req_in = 1'b0;
      gtpowergood_in = 1'b0; txpmaresetdone_in = 1'b0; rxpmaresetdone_in = 1'b0;
      tx_done_in = 1'b0; rx_done_in = 1'b0; cdr_stable_in = 1'b1;
      tick(3);
      vectors++; if ({reset_all, rx_dp, tx_act, rx_act, link_up, fault, state_out, retry_out} !== {6'b100000, 4'd0, 4'd0}) begin
         miscompares++; $display("FAIL reset_values: got %b want %b", {reset_all, rx_dp, tx_act, rx_act, link_up, fault, state_out, retry_out}, {6'b100000, 4'd0, 4'd0}); end
   endtask

   task automatic test_bringup();
      int t0, n, h, bad;
      rst_in = 1'b0;
      t0 = cyc;
      tick(1);
      vectors++; if (state_out !== 4'd1 || reset_all !== 1'b1) begin miscompares++; $display("FAIL bu_wait_pwr: state=%0d reset_all=%b want 1/1", state_out, reset_all); end
      while (cyc < t0 + 5) tick(1);
      gtpowergood_in = 1'b1;
      wait_state(4'd2, 20, n);
      vectors++; if (n != 3) begin miscompares++; $display("FAIL bu_pg_latency: got %0d want 3", n); end
      h = 0; bad = 0;
      while ((state_out == 4'd2) && (h < 100)) begin
         h++;
         if (reset_all !== 1'b1 || tx_act !== 1'b0) bad++;
         tick(1);
      end
      vectors++; if (h != 16 || bad != 0) begin miscompares++; $display("FAIL bu_reset_hold: cycles=%0d bad=%0d want 16/0", h, bad); end
      vectors++; if (state_out !== 4'd3 || reset_all !== 1'b0 || tx_act !== 1'b0) begin
         miscompares++; $display("FAIL bu_wait_pma: state=%0d reset_all=%b tx_act=%b want 3/0/0", state_out, reset_all, tx_act); end
      while (cyc < t0 + 100) tick(1);
      txpmaresetdone_in = 1'b1; rxpmaresetdone_in = 1'b1;
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         tick(1);
         if (tx_act === 1'b1) begin n = i; break; end
      end
      vectors++; if (n != 66) begin miscompares++; $display("FAIL bu_settle: got %0d want 66", n); end
      vectors++; if (state_out !== 4'd4 || rx_act !== 1'b1) begin miscompares++; $display("FAIL bu_wait_tx: state=%0d rx_act=%b want 4/1", state_out, rx_act); end
      while (cyc < t0 + 300) tick(1);
      tx_done_in = 1'b1;
      tick(2);
      vectors++; if (state_out !== 4'd4) begin miscompares++; $display("FAIL bu_tx_sync: state=%0d want 4", state_out); end
      tick(1);
      vectors++; if (state_out !== 4'd5) begin miscompares++; $display("FAIL bu_wait_rx: state=%0d want 5", state_out); end
      while (cyc < t0 + 400) tick(1);
      rx_done_in = 1'b1;
      tick(3);
      vectors++; if ({state_out, link_up, retry_out, reset_all, fault} !== {4'd6, 1'b1, 4'd0, 1'b0, 1'b0}) begin
         miscompares++; $display("FAIL bu_link_up: state=%0d link_up=%b retry=%0d reset_all=%b fault=%b want 6/1/0/0/0", state_out, link_up, retry_out, reset_all, fault); end
   endtask

   task automatic test_cdr_filter();
      int n, h, bad;
      cdr_stable_in = 1'b0;
      tick(7);
      cdr_stable_in = 1'b1;
      tick(12);
      vectors++; if (state_out !== 4'd6 || rx_dp !== 1'b0) begin miscompares++; $display("FAIL cdr_7_low: state=%0d rx_dp=%b want 6/0", state_out, rx_dp); end
      cdr_stable_in = 1'b0; rx_done_in = 1'b0;
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         tick(1);
         if (i == 8) cdr_stable_in = 1'b1;
         if (rx_dp === 1'b1) begin n = i; break; end
      end
      cdr_stable_in = 1'b1;
      vectors++; if (n != 10 || state_out !== 4'd7) begin miscompares++; $display("FAIL cdr_8_low: latency=%0d state=%0d want 10/7", n, state_out); end
      h = 0; bad = 0;
      while ((rx_dp === 1'b1) && (h < 100)) begin
         h++;
         if (reset_all !== 1'b0 || rx_act !== 1'b1) bad++;
         tick(1);
      end
      vectors++; if (h != 16 || bad != 0) begin miscompares++; $display("FAIL cdr_rx_pulse: cycles=%0d bad=%0d want 16/0", h, bad); end
      vectors++; if (state_out !== 4'd5) begin miscompares++; $display("FAIL cdr_wait_rx: state=%0d want 5", state_out); end
      rx_done_in = 1'b1;
      tick(3);
      vectors++; if (state_out !== 4'd6 || reset_all !== 1'b0) begin miscompares++; $display("FAIL cdr_relink: state=%0d reset_all=%b want 6/0", state_out, reset_all); end
   endtask

   task automatic test_rx_req_ignored();
      int n, saw;
      tx_done_in = 1'b0;
      tick(3);
      vectors++; if (state_out !== 4'd2 || retry_out !== 4'd0) begin miscompares++; $display("FAIL txloss_rst_all: state=%0d retry=%0d want 2/0", state_out, retry_out); end
      wait_state(4'd4, 300, n);
      vectors++; if (n < 0) begin miscompares++; $display("FAIL req_reach_wait_tx: timed out, state=%0d want 4", state_out); end
      rx_reset_req_in = 1'b1;
      tick(5);
      rx_reset_req_in = 1'b0;
      tick(3);
      vectors++; if (state_out !== 4'd4 || rx_dp !== 1'b0) begin miscompares++; $display("FAIL req_ignored: state=%0d rx_dp=%b want 4/0", state_out, rx_dp); end
      tx_done_in = 1'b1;
      saw = 0; n = -1;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         if (state_out == 4'd7) saw = 1;
         if (state_out == 4'd6) begin n = i; break; end
      end
      vectors++; if (n != 4 || saw != 0) begin miscompares++; $display("FAIL req_not_queued: latency=%0d saw_rx_rst=%0d want 4/0", n, saw); end
      rx_reset_req_in = 1'b1;
      tick(2);
      vectors++; if (state_out !== 4'd7) begin miscompares++; $display("FAIL req_in_link_up: state=%0d want 7", state_out); end
      wait_state(4'd6, 100, n);
      rx_reset_req_in = 1'b0;
      vectors++; if (n != 17) begin miscompares++; $display("FAIL req_relink: latency=%0d want 17", n); end
   endtask

   task automatic test_timeout_fault();
      int n;
      rx_done_in = 1'b0;
      tick(5);
      vectors++; if (state_out !== 4'd6) begin miscompares++; $display("FAIL to_rxdone_ignored: state=%0d want 6", state_out); end
      rx_reset_req_in = 1'b1;
      tick(2);
      rx_reset_req_in = 1'b0;
      wait_state(4'd5, 50, n);
      n = -1;
      for (int i = 1; i <= 300; i++) begin
         tick(1);
         if (state_out != 4'd5) begin n = i; break; end
      end
      vectors++; if (n != 200 || state_out !== 4'd2 || retry_out !== 4'd1) begin
         miscompares++; $display("FAIL to_first: cycles=%0d state=%0d retry=%0d want 200/2/1", n, state_out, retry_out); end
      wait_retry(4'd2, 1000, n);
      vectors++; if (n < 0 || state_out !== 4'd2) begin miscompares++; $display("FAIL to_retry2: wait=%0d state=%0d want retry 2 in state 2", n, state_out); end
      wait_retry(4'd3, 1000, n);
      vectors++; if (n < 0 || state_out !== 4'd2) begin miscompares++; $display("FAIL to_retry3: wait=%0d state=%0d want retry 3 in state 2", n, state_out); end
      wait_state(4'd8, 1000, n);
      vectors++; if (n < 0 || {fault, reset_all, tx_act, rx_act, link_up, retry_out} !== {5'b11000, 4'd3}) begin
         miscompares++; $display("FAIL to_fault: wait=%0d fault=%b reset_all=%b tx_act=%b rx_act=%b retry=%0d want 1/1/0/0/3", n, fault, reset_all, tx_act, rx_act, retry_out); end
      tick(50);
      vectors++; if (state_out !== 4'd8 || retry_out !== 4'd3) begin miscompares++; $display("FAIL to_fault_hold: state=%0d retry=%0d want 8/3", state_out, retry_out); end
      link_restart_in = 1'b1; tx_done_in = 1'b0;
      tick(1);
      vectors++; if (state_out !== 4'd8) begin miscompares++; $display("FAIL restart_sync: state=%0d want 8", state_out); end
      tick(1);
      link_restart_in = 1'b0;
      vectors++; if (state_out !== 4'd2 || retry_out !== 4'd0) begin miscompares++; $display("FAIL restart_exit: state=%0d retry=%0d want 2/0", state_out, retry_out); end
   endtask

   task automatic test_powergood_loss();
      int n;
      wait_retry(4'd1, 1000, n);
      vectors++; if (n < 0 || state_out !== 4'd2) begin miscompares++; $display("FAIL pg_setup_retry: wait=%0d state=%0d want retry 1 in state 2", n, state_out); end
      wait_state(4'd4, 300, n);
      gtpowergood_in = 1'b0;
      tick(2);
      vectors++; if (n < 0 || state_out !== 4'd4) begin miscompares++; $display("FAIL pg_in_wait_tx: wait=%0d state=%0d want 4", n, state_out); end
      tick(1);
      vectors++; if ({state_out, tx_act, rx_act, reset_all, retry_out} !== {4'd1, 3'b001, 4'd1}) begin
         miscompares++; $display("FAIL pg_loss: state=%0d tx_act=%b rx_act=%b reset_all=%b retry=%0d want 1/0/0/1/1", state_out, tx_act, rx_act, reset_all, retry_out); end
      tick(5);
      vectors++; if (state_out !== 4'd1) begin miscompares++; $display("FAIL pg_hold: state=%0d want 1", state_out); end
      gtpowergood_in = 1'b1;
   endtask

   task automatic test_timeout_vs_restart();
      int n;
      wait_state(4'd4, 300, n);
      vectors++; if (n < 0 || retry_out !== 4'd1) begin miscompares++; $display("FAIL tr_setup: wait=%0d retry=%0d want retry 1 in state 4", n, retry_out); end
      tick(198);
      link_restart_in = 1'b1;
      tick(1);
      vectors++; if (state_out !== 4'd4 || retry_out !== 4'd1) begin miscompares++; $display("FAIL tr_before: state=%0d retry=%0d want 4/1", state_out, retry_out); end
      tick(1);
      link_restart_in = 1'b0;
      vectors++; if (state_out !== 4'd2 || retry_out !== 4'd0) begin miscompares++; $display("FAIL tr_coincide: state=%0d retry=%0d want 2/0", state_out, retry_out); end
   endtask

   task automatic test_reset_mid_rx_rst();
      int n;
      tx_done_in = 1'b1; rx_done_in = 1'b1;
      wait_state(4'd6, 500, n);
      vectors++; if (n < 0) begin miscompares++; $display("FAIL rr_link_up: timed out, state=%0d want 6", state_out); end
      rx_reset_req_in = 1'b1;
      tick(2);
      vectors++; if (state_out !== 4'd7 || rx_dp !== 1'b1) begin miscompares++; $display("FAIL rr_rx_rst: state=%0d rx_dp=%b want 7/1", state_out, rx_dp); end
      tick(4);
      rst_in = 1'b1; rx_reset_req_in = 1'b0;
      tick(1);
      vectors++; if ({reset_all, rx_dp, tx_act, rx_act, link_up, fault, state_out, retry_out} !== {6'b100000, 4'd0, 4'd0}) begin
         miscompares++; $display("FAIL rr_reset_values: got %b want %b", {reset_all, rx_dp, tx_act, rx_act, link_up, fault, state_out, retry_out}, {6'b100000, 4'd0, 4'd0}); end
      rst_in = 1'b0;
      wait_state(4'd6, 600, n);
      vectors++; if (n < 0 || retry_out !== 4'd0) begin miscompares++; $display("FAIL rr_rebringup: wait=%0d retry=%0d want link up with retry 0", n, retry_out); end
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_cdr_filter();
      test_rx_req_ignored();
      test_timeout_fault();
      test_powergood_loss();
      test_timeout_vs_restart();
      test_reset_mid_rx_rst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
